mod_const_mul_seq: RTL and testbench

//  Sequential constant modular multiplier: computes R = (X * C) mod M for a wide operand X.

---
 rtl/mod_const_mul_seq.sv | 182 ++++++++++++++++++
 tb/tb_mod_const_mul_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_const_mul_seq.sv
// mod_const_mul_seq: sequential constant modular multiplier, r = (x * C) mod M.
//
// x is consumed one DW-bit digit per cycle, MSB digit first (Horner form). Each RUN cycle
// does acc <= red(((acc << DW) mod M) + T[d]), where T[d] = (d * C) mod M.
//
// Optional feature (compile-time macro MODMUL_ADD_EN):
//   defined   -> extra input add_in, result is (x * C + add_in) mod M (add_in must be < M)
//   undefined -> no add_in port or register, result is (x * C) mod M
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand x valid
//   in_ready   out  1   high only in IDLE
//   x          in   XW  unsigned operand
//   add_in     in   RW  additive term, sampled with x (MODMUL_ADD_EN only)
//   out_valid  out  1   result valid (DONE)
//   out_ready  in   1   consumer accepts r
//   r          out  RW  result, always < M
//   busy       out  1   high in RUN or DONE

module mod_const_mul_seq #(
    parameter int unsigned M  = 503,
    parameter int unsigned C  = 500,
    parameter int unsigned DW = 6,
    parameter int unsigned XW = 36,
    parameter int unsigned RW = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] x,
`ifdef MODMUL_ADD_EN
    input  logic [RW-1:0] add_in,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] r,
    output logic          busy
);

    localparam int unsigned NDIG = XW / DW;
    localparam int unsigned NLUT = 1 << DW;
    localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [RW:0] ModV = M[RW:0];
    localparam logic [CntW-1:0] LastCnt = CntW'(NDIG - 1);

    // Elaboration-time parameter checks
    if (M < 3) begin : g_bad_m
        $error("mod_const_mul_seq: M must be >= 3");
    end
    if (C >= M) begin : g_bad_c
        $error("mod_const_mul_seq: C must be < M");
    end
    if ((XW % DW) != 0) begin : g_bad_xw
        $error("mod_const_mul_seq: XW must be a multiple of DW");
    end

    // Residue table T[d] = (d * C) mod M, evaluated at elaboration
    function automatic logic [RW-1:0] lut_entry(input int unsigned d);
        longint p;
        p = (longint'(d) * longint'(C)) % longint'(M);
        return p[RW-1:0];
    endfunction

    logic [RW-1:0] lut [NLUT];

    for (genvar g = 0; g < NLUT; g++) begin : g_lut
        assign lut[g] = lut_entry(g);
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   shreg_q, shreg_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   digit;
    logic [RW-1:0]   step;

    assign digit = shreg_q[XW-1 -: DW];

`ifdef MODMUL_ADD_EN
    logic [RW-1:0] add_q, add_d;
    logic [RW-1:0] step_add;
`endif

    // One Horner step: scale acc by 2^DW mod M via DW double-and-reduce stages, then add T[d].
    // Every intermediate stays below 2M, so RW+1 bits suffice.
    always_comb begin
        logic [RW-1:0] red;
        logic [RW:0]   dbl;
        logic [RW:0]   sum;
        red = acc_q;
        for (int i = 0; i < DW; i++) begin
            dbl = {red, 1'b0};
            red = RW'((dbl >= ModV) ? (dbl - ModV) : dbl);
        end
        sum  = {1'b0, red} + {1'b0, lut[digit]};
        step = RW'((sum >= ModV) ? (sum - ModV) : sum);
    end

`ifdef MODMUL_ADD_EN
    // The additive term is folded in on the last digit, after the final scaling
    always_comb begin
        logic [RW:0] sum2;
        sum2     = {1'b0, step} + {1'b0, add_q};
        step_add = RW'((sum2 >= ModV) ? (sum2 - ModV) : sum2);
    end
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef MODMUL_ADD_EN
        add_d   = add_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StRun;
                    shreg_d = x;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef MODMUL_ADD_EN
                    add_d   = add_in;
`endif
                end
            end
            StRun: begin
                acc_d   = step;
                shreg_d = shreg_q << DW;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
`ifdef MODMUL_ADD_EN
                    acc_d   = step_add;
`endif
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MODMUL_ADD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_q <= '0;
        end else begin
            add_q <= add_d;
        end
    end
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign r         = acc_q;

endmodule

// File: tb/tb_mod_const_mul_seq.sv
module tb_mod_const_mul_seq;

    localparam int unsigned M    = 503;
    localparam int unsigned C    = 500;
    localparam int unsigned DW   = 6;
    localparam int unsigned XW   = 36;
    localparam int unsigned RW   = 9;
    localparam int unsigned NDIG = XW / DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [XW-1:0] x = '0;
    logic [RW-1:0] add_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [RW-1:0] r;
    logic          busy;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    mod_const_mul_seq #(
        .M  (M),
        .C  (C),
        .DW (DW),
        .XW (XW),
        .RW (RW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
`ifdef MODMUL_ADD_EN
        .add_in    (add_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] x;
        logic [RW-1:0] exp;
    } vec_t;

    // Reference: plain arithmetic on the whole operand
    function automatic logic [RW-1:0] ref_model(input logic [XW-1:0] xv, input logic [RW-1:0] av);
        longint p;
        p = (longint'(xv) * longint'(C) + longint'(av)) % longint'(M);
        return p[RW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Starts one operation and waits for out_valid; leaves the DUT in DONE.
    task automatic start_and_wait(input logic [XW-1:0] xv, input logic [RW-1:0] av,
                                  output logic [RW-1:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        x        = xv;
        add_in   = av;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x        = XW'({$urandom(), $urandom()});
        lat      = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = r;
    endtask

    task automatic handshake();
        @(posedge clk); #1;
    endtask

    vec_t          vecs[$];
    logic [RW-1:0] res;
    int            lat;
    logic [XW-1:0] rx;
    logic [RW-1:0] ra;
    bit            stable;

    initial begin
        vecs.push_back('{x: 36'd63,          exp: 9'd314});
        vecs.push_back('{x: 36'd0,           exp: 9'd0});
        vecs.push_back('{x: 36'd503,         exp: 9'd0});
        vecs.push_back('{x: 36'd504,         exp: 9'd500});
        vecs.push_back('{x: 36'hF_FFFF_FFFF, exp: 9'd440});
        vecs.push_back('{x: 36'd1,           exp: 9'd500});
        vecs.push_back('{x: 36'd2,           exp: 9'd497});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset r", 64'(r), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // x=1: latency and return to IDLE
        start_and_wait(36'd1, '0, res, lat);
        check("x=1 r", 64'(res), 64'd500);
        check("x=1 latency", 64'(lat), 64'(NDIG));
        check("x=1 busy in DONE", 64'(busy), 64'd1);
        handshake();
        check("x=1 in_ready after", 64'(in_ready), 64'd1);
        check("x=1 out_valid after", 64'(out_valid), 64'd0);

        // Directed table
        foreach (vecs[i]) begin
            start_and_wait(vecs[i].x, '0, res, lat);
            check($sformatf("table[%0d] x=%0d", i, vecs[i].x), 64'(res), 64'(vecs[i].exp));
            handshake();
        end

        // Random operands against the model
        for (int k = 0; k < 3000; k++) begin
            rx = XW'({$urandom(), $urandom()});
            if (k % 4 == 0) rx = XW'($urandom_range(0, 4 * M));
            start_and_wait(rx, '0, res, lat);
            check($sformatf("rand x=%0d", rx), 64'(res), 64'(ref_model(rx, '0)));
            handshake();
        end

        // Stall in DONE; new operands offered meanwhile must be ignored
        out_ready = 1'b0;
        start_and_wait(36'd504, '0, res, lat);
        check("stall r", 64'(res), 64'd500);
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            x        = XW'({$urandom(), $urandom()});
            @(posedge clk); #1;
            if (r !== 9'd500 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        check("stall stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall release in_ready", 64'(in_ready), 64'd1);
        check("stall release out_valid", 64'(out_valid), 64'd0);
        start_and_wait(36'd63, '0, res, lat);
        check("after stall x=63", 64'(res), 64'd314);
        handshake();

        // Reset mid-operation
        x        = 36'd63;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_and_wait(36'd1, '0, res, lat);
        check("midrst next x=1", 64'(res), 64'd500);
        check("midrst next latency", 64'(lat), 64'(NDIG));
        handshake();

`ifdef MODMUL_ADD_EN
        start_and_wait(36'd1, 9'd3, res, lat);
        check("add x=1 a=3", 64'(res), 64'd0);
        handshake();
        start_and_wait(36'd0, 9'd502, res, lat);
        check("add x=0 a=502", 64'(res), 64'd502);
        handshake();
        for (int k = 0; k < 500; k++) begin
            rx = XW'({$urandom(), $urandom()});
            ra = RW'($urandom_range(0, M - 1));
            start_and_wait(rx, ra, res, lat);
            check($sformatf("add rand x=%0d a=%0d", rx, ra), 64'(res), 64'(ref_model(rx, ra)));
            handshake();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
